fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Downstream consumer of the synchronous byte FIFO (fifo_buffer). It pops one byte at a time whenever the FIFO is non-empty and serializes it onto a single UART-style line: 1 start bit, DATA_WIDTH data bits LSB first, and 1 stop bit, with no parity. It drives the FIFO's read enable directly and uses the FIFO's empty flag and data output, so it drains the buffer at line rate.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range is 2 or more.
DATA_WIDTH, 8, FIFO word width and number of data bits per frame.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
fifo_empty  input  1  empty flag from the FIFO.
fifo_data  input  DATA_WIDTH  FIFO data_out; registered read, so valid the cycle after fifo_rd_e is sampled high.
fifo_rd_e  output  1  read enable to the FIFO; high for exactly one cycle per byte popped.
tx  output  1  serial line; idles high.
busy  output  1  high in every state except IDLE.
tx_done  output  1  one-cycle pulse after a frame's stop bit completes.

Behaviour:
- Reset (synchronous, wins over everything):
  - State goes to IDLE; tx=1, fifo_rd_e=0, busy=0, tx_done=0.
  - Bit and clock counters and the shift register are cleared.
  - A frame in progress is abandoned: tx returns to 1 on the edge where reset is sampled. The popped byte is lost, not re-fetched.
- tx, busy and tx_done are registered or state-decoded with no combinational path from inputs. fifo_rd_e = (state==FETCH).
- States: IDLE, FETCH, LOAD, START, DATA, STOP.
  - IDLE: tx=1. If fifo_empty==0 → FETCH, else stay.
  - FETCH: exactly 1 cycle, fifo_rd_e=1 → LOAD.
  - LOAD: exactly 1 cycle, FIFO data now valid. At the exiting edge, capture fifo_data into the shift register and set tx=0 → START.
  - START: tx=0 for CLKS_PER_BIT cycles → DATA, with tx=shift[0].
  - DATA: each bit is held for CLKS_PER_BIT cycles, then shift right and increment the bit counter. After bit DATA_WIDTH-1 completes → STOP, tx=1.
  - STOP: tx=1 for CLKS_PER_BIT cycles → IDLE, with tx_done=1 during that first IDLE cycle only.
- Timing:
  - Frame length on the line is (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
  - Latency from fifo_empty falling while in IDLE to the tx falling edge is 3 clk edges (IDLE→FETCH→LOAD→START).
  - Back-to-back bytes: minimum idle gap between a stop bit and the next start bit is 3 cycles (IDLE, FETCH, LOAD).
- Boundaries:
  - fifo_empty is sampled only in IDLE. Changes in other states are ignored.
  - The FIFO becoming empty after the last pop returns the block to IDLE and holds tx=1 with no extra read.
  - The block never asserts fifo_rd_e while fifo_empty==1, so there is no underflow read.
  - The clock counter is $clog2(CLKS_PER_BIT) bits and wraps to 0 at CLKS_PER_BIT-1. The bit counter is $clog2(DATA_WIDTH) bits, or 1 bit minimum.
  - The captured byte is immune to fifo_data changes after the LOAD edge.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with fifo_empty=0 → tx=1, fifo_rd_e=0, busy=0, tx_done=0 throughout; no read issued.
2. Single byte, CLKS_PER_BIT=4, FIFO model returns 0x01 → one fifo_rd_e pulse; tx bits per 4-cycle slot read 0,1,0,0,0,0,0,0,0,1. busy is high for 42 cycles (FETCH through STOP). tx_done pulses once, 40 cycles after tx first falls.
3. Byte 0xA5 → data slots read 1,0,1,0,0,1,0,1 (LSB first); stop slot is 1.
4. Eight queued bytes (0x01,0x09,0x07,0x03,0x04,0x06,0x08,0x0A) with empty deasserted → exactly 8 fifo_rd_e pulses; frames decoded in order; 3-cycle tx-high gap between frames; tx idle and busy=0 after the last pop.
5. Reset asserted mid-DATA (bit 3 of 0xFF) → tx=1 and state IDLE on the next edge. With fifo_empty=0 after reset release, a new fetch starts 1 cycle later.
6. fifo_empty toggled high and then low during a frame → no additional fifo_rd_e until the block is back in IDLE; the frame completes unchanged.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Drains a synchronous byte FIFO onto a UART-style serial line. Whenever the
//   FIFO reports non-empty while idle, one word is popped and sent as an
//   8N1-style frame: start bit (0), DATA_WIDTH data bits LSB first, stop bit (1).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2 or more)
//   DATA_WIDTH    FIFO word width and data bits per frame
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   fifo_empty  FIFO empty flag, sampled only in IDLE
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_e
//   fifo_rd_e   FIFO read enable, one cycle per popped word
//   tx          serial line, idles high
//   busy        high whenever a pop or frame is in progress
//   tx_done     one-cycle pulse after a frame's stop bit
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_e,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

   state_t                state;
   logic [CW-1:0]         clk_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shift;
   logic [DATA_WIDTH-1:0] shift_nxt;
   logic                  clk_last;

   // Read enable is decoded from state so the pop happens in FETCH and the
   // registered FIFO output is ready to capture one cycle later in LOAD.
   assign fifo_rd_e = (state == FETCH);
   assign busy      = (state != IDLE);
   assign clk_last  = (clk_cnt == CLK_LAST);
   assign shift_nxt = shift >> 1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         tx      <= 1'b1;
         tx_done <= 1'b0;
         clk_cnt <= '0;
         bit_cnt <= '0;
         shift   <= '0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (!fifo_empty) state <= FETCH;
            end
            FETCH: state <= LOAD;
            LOAD: begin
               // Word is captured here; later fifo_data changes cannot leak in.
               shift   <= fifo_data;
               tx      <= 1'b0;
               clk_cnt <= '0;
               bit_cnt <= '0;
               state   <= START;
            end
            START: begin
               if (clk_last) begin
                  clk_cnt <= '0;
                  tx      <= shift[0];
                  state   <= DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            DATA: begin
               if (clk_last) begin
                  clk_cnt <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shift   <= shift_nxt;
                     tx      <= shift_nxt[0];
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            STOP: begin
               if (clk_last) begin
                  clk_cnt <= '0;
                  tx_done <= 1'b1;
                  state   <= IDLE;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
//   Drives fifo_uart_tx from a behavioural registered-read FIFO model. Every
//   byte pushed into the model is also pushed to a scoreboard; a line monitor
//   decodes each frame slot by slot and compares against the scoreboard.
module tb_fifo_uart_tx;
   localparam int CPB = 4;
   localparam int DW  = 8;
   localparam int FRAME_CYC = (DW + 2) * CPB;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          hold_empty = 1'b0;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_empty;
   logic          fifo_rd_e, tx, busy, tx_done;

   int            pushed = 0, popped = 0;
   int            n_chk = 0, n_fail = 0;
   int            rd_cnt = 0, done_cnt = 0, n_exp = 0, cyc = 0;
   bit            mon_en = 1'b1, gap_chk = 1'b0, have_last = 1'b0;
   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_q[$];

   assign fifo_empty = (pushed == popped) || hold_empty;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd_e(fifo_rd_e), .tx(tx), .busy(busy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_raw(input logic [DW-1:0] b);
      fq.push_back(b);
      pushed++;
   endtask

   task automatic push(input logic [DW-1:0] b);
      push_raw(b);
      exp_q.push_back(b);
      n_exp++;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((pushed != popped || busy) && n < max);
      chk("wait_idle", {30'd0, pushed != popped, busy}, 32'd0);
   endtask

   // FIFO model: registered read; data bus scrambled on non-read cycles.
   initial forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      if (fifo_rd_e && fq.size() != 0) begin
         fifo_data <= fq.pop_front();
         popped    <= popped + 1;
      end else begin
         fifo_data <= DW'($urandom);
      end
   end

   // Read / done counters, underflow and busy-length checks.
   initial begin
      int brun = 0;
      forever begin
         @(negedge clk);
         if (fifo_rd_e) begin
            rd_cnt++;
            chk("rd_underflow", {31'd0, fifo_empty}, 32'd0);
         end
         if (tx_done) done_cnt++;
         if (reset) brun = 0;
         else if (busy) brun++;
         else if (brun != 0) begin
            chk("busy_len", brun, FRAME_CYC + 2);
            brun = 0;
         end
      end
   end

   // Line monitor / scoreboard consumer.
   initial begin
      logic          prev_tx = 1'b1;
      logic [DW-1:0] eb, rx;
      logic [DW+1:0] frame;
      int            start_cyc, last_end = 0, bad;
      forever begin
         @(negedge clk);
         if (mon_en && !reset && prev_tx && !tx) begin
            start_cyc = cyc;
            if (gap_chk && have_last) chk("gap", start_cyc - last_end - 1, 3);
            chk("sb_avail", {31'd0, exp_q.size() != 0}, 32'd1);
            eb = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            frame = {1'b1, eb, 1'b0};
            bad = 0;
            rx = '0;
            for (int s = 0; s < DW + 2; s++) begin
               for (int c = 0; c < CPB; c++) begin
                  if (s != 0 || c != 0) @(negedge clk);
                  if (tx !== frame[s]) bad++;
                  if (c == CPB / 2 && s >= 1 && s <= DW) rx[s-1] = tx;
               end
            end
            last_end = cyc;
            chk("frame_byte", rx, eb);
            chk("frame_slots", bad, 0);
            @(negedge clk);
            chk("tx_done", {31'd0, tx_done}, 32'd1);
            chk("tx_done_lat", cyc - start_cyc, FRAME_CYC);
            have_last = 1'b1;
         end
         prev_tx = tx;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd0;
      logic [DW-1:0] burst [8] = '{8'h01, 8'h09, 8'h07, 8'h03, 8'h04, 8'h06, 8'h08, 8'h0A};

      // Reset held with a word already available: nothing may move.
      reset = 1'b1;
      push(8'h01);
      repeat (2) begin
         @(negedge clk);
         chk("rst_tx", {31'd0, tx}, 32'd1);
         chk("rst_rd", {31'd0, fifo_rd_e}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_done", {31'd0, tx_done}, 32'd0);
      end

      // Single byte 0x01 after release.
      reset = 1'b0;
      rd0 = rd_cnt;
      wait_idle(300);
      repeat (3) @(negedge clk);
      chk("t2_rd", rd_cnt - rd0, 1);

      // 0xA5 with start-bit latency from empty falling.
      push(8'hA5);
      repeat (2) @(negedge clk);
      chk("lat_hi", {31'd0, tx}, 32'd1);
      @(negedge clk);
      chk("lat_lo", {31'd0, tx}, 32'd0);
      wait_idle(300);
      repeat (3) @(negedge clk);

      // Eight queued bytes back to back.
      have_last = 1'b0;
      gap_chk = 1'b1;
      rd0 = rd_cnt;
      foreach (burst[i]) push(burst[i]);
      wait_idle(2000);
      repeat (3) @(negedge clk);
      gap_chk = 1'b0;
      chk("t4_rd", rd_cnt - rd0, 8);
      chk("t4_tx_idle", {31'd0, tx}, 32'd1);
      chk("t4_busy", {31'd0, busy}, 32'd0);

      // Reset in the middle of data bit 3 of 0xFF; that byte is lost.
      mon_en = 1'b0;
      push_raw(8'hFF);
      repeat (20) @(negedge clk);
      chk("t5_pre_tx", {31'd0, tx}, 32'd1);
      chk("t5_pre_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_rst_tx", {31'd0, tx}, 32'd1);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      push(8'h5A);
      mon_en = 1'b1;
      reset = 1'b0;
      @(negedge clk);
      chk("t5_fetch", {31'd0, fifo_rd_e}, 32'd1);
      wait_idle(300);
      repeat (3) @(negedge clk);

      // fifo_empty toggled mid-frame must not cause extra reads.
      rd0 = rd_cnt;
      push(8'h3C);
      push(8'hC3);
      repeat (10) @(negedge clk);
      chk("t6_rd_mid", rd_cnt - rd0, 1);
      hold_empty = 1'b1;
      repeat (8) @(negedge clk);
      hold_empty = 1'b0;
      repeat (8) @(negedge clk);
      chk("t6_no_extra", rd_cnt - rd0, 1);
      wait_idle(600);
      repeat (3) @(negedge clk);
      chk("t6_rd", rd_cnt - rd0, 2);

      chk("sb_drained", exp_q.size(), 0);
      chk("done_cnt", done_cnt, n_exp);
      chk("rd_total", rd_cnt, pushed);
      chk("end_tx", {31'd0, tx}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
